seg7_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment scan controller; next generation of the board display driver.
- Drives DIGITS hex digits from a CPU-written shadow register.
- Shadow copies into the active register only at frame boundaries, so the display never tears.
- Adds per-digit decimal points, leading-zero suppression, 16-level PWM brightness, anti-ghost blanking and a frame-strobe output.
- Sits on the I/O bus beside the LED/switch peripherals; feeds the board segment/anode pins.

---
 rtl/seg7_pkg.sv | 16 +
 rtl/seg7_lz_mask.sv | 26 ++
 rtl/seg7_scan_ctrl.sv | 171 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seg7 scan controller: the hex-to-segment
// table (active-low, bit7 = dp), the all-off pattern and a one-hot select builder.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] seg7_onehot(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// Leading-blank mask: bit k set means digit k sits in the leading run of zero
// nibbles with dp clear and is blanked; digit 0 always stays visible.
module seg7_lz_mask #(
  parameter int DIGITS = 8
) (
  input  logic [4*DIGITS-1:0] data_i,
  input  logic [DIGITS-1:0]   dp_i,
  input  logic                lz_en_i,
  output logic [DIGITS-1:0]   mask_o
);

  logic run;

  always_comb begin
    mask_o = '0;
    run    = lz_en_i;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (run && (k != 0) && (data_i[4*k +: 4] == 4'h0) && !dp_i[k]) begin
        mask_o[k] = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-synchronous shadow copy,
// dp, leading-zero blanking, PWM brightness and guard blanking.
// Optional blink support is compiled in with `define SEG7_BLINK_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int SCAN_DIV_W  = 14,
  parameter int GUARD_CYC   = 4,
  parameter int SEG_ACT_LOW = 1,
  parameter int SEL_ACT_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs,
  input  logic [4*DIGITS-1:0] i_data,
  input  logic [DIGITS-1:0]   i_dp,
  input  logic                i_lz_en,
  input  logic [3:0]          i_bright,
`ifdef SEG7_BLINK_EN
  input  logic [DIGITS-1:0]   i_blink,
`endif
  output logic [7:0]          o_seg,
  output logic [DIGITS-1:0]   o_sel,
  output logic                o_frame
);

  localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [7:0]        SEG_RST  = (SEG_ACT_LOW != 0) ? SEG_OFF : ~SEG_OFF;
  localparam logic [DIGITS-1:0] SEL_OFF  = (SEL_ACT_LOW != 0) ? '1 : '0;

  logic [SCAN_DIV_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tick, frame_end;

  logic [4*DIGITS-1:0]   sh_data_q, sh_data_d, act_data_q, act_data_d;
  logic [DIGITS-1:0]     sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic                  sh_lz_q, sh_lz_d, act_lz_q, act_lz_d;
  logic [3:0]            sh_bright_q, sh_bright_d, act_bright_q, act_bright_d;

  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     sel_q, sel_d;

  logic [3:0]            nib_w [DIGITS];
  logic [DIGITS-1:0]     lz_mask_w;
  logic                  blink_blank;
  logic                  blank;
  logic                  gate;
  logic [7:0]            seg_al;
  logic [7:0]            oh8;
  logic [DIGITS-1:0]     oh;

  assign tick      = &cnt_q;
  assign frame_end = tick && (idx_q == IDX_LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // A write landing on the frame-end edge goes straight to the active copy.
  always_comb begin
    sh_data_d   = cs ? i_data   : sh_data_q;
    sh_dp_d     = cs ? i_dp     : sh_dp_q;
    sh_lz_d     = cs ? i_lz_en  : sh_lz_q;
    sh_bright_d = cs ? i_bright : sh_bright_q;
    act_data_d   = frame_end ? sh_data_d   : act_data_q;
    act_dp_d     = frame_end ? sh_dp_d     : act_dp_q;
    act_lz_d     = frame_end ? sh_lz_d     : act_lz_q;
    act_bright_d = frame_end ? sh_bright_d : act_bright_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_lz_q      <= 1'b0;
      sh_bright_q  <= 4'hF;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_lz_q     <= 1'b0;
      act_bright_q <= 4'hF;
      seg_q        <= SEG_RST;
      sel_q        <= SEL_OFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      sh_lz_q      <= sh_lz_d;
      sh_bright_q  <= sh_bright_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_lz_q     <= act_lz_d;
      act_bright_q <= act_bright_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
    end
  end

`ifdef SEG7_BLINK_EN
  logic [DIGITS-1:0] sh_blink_q, sh_blink_d, act_blink_q, act_blink_d;
  logic [4:0]        fcnt_q, fcnt_d;

  always_comb begin
    sh_blink_d  = cs ? i_blink : sh_blink_q;
    act_blink_d = frame_end ? sh_blink_d : act_blink_q;
    fcnt_d      = frame_end ? fcnt_q + 5'd1 : fcnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_blink_q  <= '0;
      act_blink_q <= '0;
      fcnt_q      <= '0;
    end else begin
      sh_blink_q  <= sh_blink_d;
      act_blink_q <= act_blink_d;
      fcnt_q      <= fcnt_d;
    end
  end

  assign blink_blank = fcnt_q[4] & act_blink_q[idx_q];
`else
  assign blink_blank = 1'b0;
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_nib
    assign nib_w[k] = act_data_q[4*k +: 4];
  end

  seg7_lz_mask #(
    .DIGITS (DIGITS)
  ) u_lz_mask (
    .data_i  (act_data_q),
    .dp_i    (act_dp_q),
    .lz_en_i (act_lz_q),
    .mask_o  (lz_mask_w)
  );

  // Segment and select are both computed from the same index/counter state
  // and registered together so they never skew.
  always_comb begin
    blank  = lz_mask_w[idx_q] | blink_blank;
    seg_al = SEG_OFF;
    if (!blank) begin
      seg_al = SEG_TABLE[nib_w[idx_q]] & ~{act_dp_q[idx_q], 7'b000_0000};
    end
    seg_d = (SEG_ACT_LOW != 0) ? seg_al : ~seg_al;

    oh8   = seg7_onehot(3'(idx_q));
    oh    = oh8[DIGITS-1:0];
    gate  = (cnt_q >= SCAN_DIV_W'(GUARD_CYC)) &&
            (cnt_q[SCAN_DIV_W-1 -: 4] <= act_bright_q);
    sel_d = SEL_OFF;
    if (gate) begin
      sel_d = (SEL_ACT_LOW != 0) ? ~oh : oh;
    end
  end

  assign o_seg   = seg_q;
  assign o_sel   = sel_q;
  assign o_frame = frame_end;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl (DIGITS=8, SCAN_DIV_W=5, GUARD_CYC=2).
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic [31:0] i_data = '0;
  logic [7:0]  i_dp = '0;
  logic        i_lz_en = 1'b0;
  logic [3:0]  i_bright = 4'hF;
  wire  [7:0]  o_seg;
  wire  [7:0]  o_sel;
  wire         o_frame;

  int checks = 0;
  int errors = 0;
  int pos = 0;

  // Expected segments for 32'h0123ABCF, digit 0 first.
  localparam logic [7:0] EXP_A [8] = '{8'h8E, 8'hC6, 8'h83, 8'h88,
                                       8'hB0, 8'hA4, 8'hF9, 8'hC0};

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .DIGITS      (8),
    .SCAN_DIV_W  (5),
    .GUARD_CYC   (2),
    .SEG_ACT_LOW (1),
    .SEL_ACT_LOW (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .i_data   (i_data),
    .i_dp     (i_dp),
    .i_lz_en  (i_lz_en),
    .i_bright (i_bright),
    .o_seg    (o_seg),
    .o_sel    (o_sel),
    .o_frame  (o_frame)
  );

  // Ends on the negedge where o_frame is high; pos counts posedges from there.
  task automatic wait_frame();
    bit seen = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (o_frame === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL frame_timeout: o_frame not seen within 600 cycles");
    end
    pos = 0;
  endtask

  // Registered outputs reflecting slot (d,c) appear after edge d*32+c+2.
  task automatic seek(input int d, input int c);
    int t = d * 32 + c + 2;
    while (pos < t) begin
      @(posedge clk);
      pos++;
    end
    @(negedge clk);
  endtask

  task automatic write(input logic [31:0] d, input logic [7:0] dp,
                       input logic lz, input logic [3:0] br);
    i_data   = d;
    i_dp     = dp;
    i_lz_en  = lz;
    i_bright = br;
    cs       = 1'b1;
    @(posedge clk);
    pos++;
    #1 cs = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (o_seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h want FF", o_seg); end
    checks++;
    if (o_sel !== 8'hFF) begin errors++; $display("FAIL reset_sel: got %h want FF", o_sel); end
    checks++;
    if (o_frame !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b want 0", o_frame); end
    reset = 1'b0;
  endtask

  task automatic test_decode();
    logic [7:0] exp_sel;
    int n;
    write(32'h0123ABCF, 8'h00, 1'b0, 4'hF);
    wait_frame();
    for (int d = 0; d < 8; d++) begin
      exp_sel = ~(8'h01 << d);
      seek(d, 1);
      checks++;
      if (o_sel !== 8'hFF) begin errors++; $display("FAIL guard_sel d%0d: got %h want FF", d, o_sel); end
      seek(d, 2);
      checks++;
      if (o_sel !== exp_sel) begin errors++; $display("FAIL walk_sel d%0d: got %h want %h", d, o_sel, exp_sel); end
      seek(d, 10);
      checks++;
      if (o_seg !== EXP_A[d]) begin errors++; $display("FAIL decode_seg d%0d: got %h want %h", d, o_seg, EXP_A[d]); end
    end
    wait_frame();
    n = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n++;
      if (o_frame === 1'b1) break;
    end
    checks++;
    if (n !== 256) begin errors++; $display("FAIL frame_period: got %0d want 256", n); end
    pos = 0;
  endtask

  task automatic test_lz();
    seek(3, 0);
    write(32'h00000050, 8'h00, 1'b1, 4'hF);
    wait_frame();
    seek(0, 10);
    checks++;
    if (o_seg !== 8'hC0) begin errors++; $display("FAIL lz_d0: got %h want C0", o_seg); end
    seek(1, 10);
    checks++;
    if (o_seg !== 8'h92) begin errors++; $display("FAIL lz_d1: got %h want 92", o_seg); end
    seek(2, 10);
    checks++;
    if (o_seg !== 8'hFF) begin errors++; $display("FAIL lz_d2_seg: got %h want FF", o_seg); end
    checks++;
    if (o_sel !== 8'hFB) begin errors++; $display("FAIL lz_d2_sel: got %h want FB", o_sel); end
    seek(7, 10);
    checks++;
    if (o_seg !== 8'hFF) begin errors++; $display("FAIL lz_d7_seg: got %h want FF", o_seg); end
    checks++;
    if (o_sel !== 8'h7F) begin errors++; $display("FAIL lz_d7_sel: got %h want 7F", o_sel); end
    wait_frame();
    seek(3, 0);
    write(32'h00000000, 8'h00, 1'b1, 4'hF);
    wait_frame();
    seek(0, 10);
    checks++;
    if (o_seg !== 8'hC0) begin errors++; $display("FAIL lz_zero_d0: got %h want C0", o_seg); end
    seek(1, 10);
    checks++;
    if (o_seg !== 8'hFF) begin errors++; $display("FAIL lz_zero_d1: got %h want FF", o_seg); end
  endtask

  task automatic test_dp();
    wait_frame();
    seek(3, 0);
    write(32'h00000000, 8'h04, 1'b1, 4'hF);
    wait_frame();
    seek(0, 10);
    checks++;
    if (o_seg !== 8'hC0) begin errors++; $display("FAIL dp_d0: got %h want C0", o_seg); end
    seek(1, 10);
    checks++;
    if (o_seg !== 8'hC0) begin errors++; $display("FAIL dp_d1: got %h want C0", o_seg); end
    seek(2, 10);
    checks++;
    if (o_seg !== 8'h40) begin errors++; $display("FAIL dp_d2: got %h want 40", o_seg); end
    seek(3, 10);
    checks++;
    if (o_seg !== 8'hFF) begin errors++; $display("FAIL dp_d3: got %h want FF", o_seg); end
  endtask

  task automatic test_bright();
    int on;
    seek(4, 0);
    write(32'h0123ABCF, 8'h00, 1'b0, 4'd3);
    wait_frame();
    seek(1, 7);
    checks++;
    if (o_sel !== 8'hFD) begin errors++; $display("FAIL bright3_c7: got %h want FD", o_sel); end
    seek(1, 8);
    checks++;
    if (o_sel !== 8'hFF) begin errors++; $display("FAIL bright3_c8: got %h want FF", o_sel); end
    on = 0;
    for (int c = 0; c < 32; c++) begin
      seek(2, c);
      if (o_sel !== 8'hFF) on++;
    end
    checks++;
    if (on !== 6) begin errors++; $display("FAIL bright3_duty: got %0d want 6", on); end
    seek(4, 0);
    write(32'h0123ABCF, 8'h00, 1'b0, 4'd0);
    wait_frame();
    on = 0;
    for (int c = 0; c < 32; c++) begin
      seek(0, c);
      if (o_sel !== 8'hFF) on++;
    end
    checks++;
    if (on !== 0) begin errors++; $display("FAIL bright0_duty: got %0d want 0", on); end
  endtask

  task automatic test_back_to_back();
    seek(3, 0);
    write(32'h0123ABCF, 8'h00, 1'b0, 4'hF);
    wait_frame();
    seek(3, 0);
    write(32'h11111111, 8'h00, 1'b0, 4'hF);
    seek(4, 10);
    checks++;
    if (o_seg !== 8'hB0) begin errors++; $display("FAIL midframe_d4: got %h want B0", o_seg); end
    seek(7, 10);
    checks++;
    if (o_seg !== 8'hC0) begin errors++; $display("FAIL midframe_d7: got %h want C0", o_seg); end
    wait_frame();
    seek(4, 10);
    checks++;
    if (o_seg !== 8'hF9) begin errors++; $display("FAIL nextframe_d4: got %h want F9", o_seg); end
    seek(7, 10);
    checks++;
    if (o_seg !== 8'hF9) begin errors++; $display("FAIL nextframe_d7: got %h want F9", o_seg); end
    wait_frame();
    write(32'h55555555, 8'h00, 1'b0, 4'hF);
    seek(0, 10);
    checks++;
    if (o_seg !== 8'h92) begin errors++; $display("FAIL bypass_d0: got %h want 92", o_seg); end
    seek(6, 10);
    checks++;
    if (o_seg !== 8'h92) begin errors++; $display("FAIL bypass_d6: got %h want 92", o_seg); end
    wait_frame();
    seek(0, 10);
    checks++;
    if (o_seg !== 8'h92) begin errors++; $display("FAIL bypass_shadow: got %h want 92", o_seg); end
  endtask

  task automatic test_reset_mid();
    int n;
    seek(2, 15);
    checks++;
    if (o_seg !== 8'h92) begin errors++; $display("FAIL pre_reset_seg: got %h want 92", o_seg); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (o_seg !== 8'hFF) begin errors++; $display("FAIL midreset_seg: got %h want FF", o_seg); end
    checks++;
    if (o_sel !== 8'hFF) begin errors++; $display("FAIL midreset_sel: got %h want FF", o_sel); end
    checks++;
    if (o_frame !== 1'b0) begin errors++; $display("FAIL midreset_frame: got %b want 0", o_frame); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == 1) begin
        checks++;
        if (o_seg !== 8'hC0) begin errors++; $display("FAIL postreset_seg: got %h want C0", o_seg); end
      end
      if (o_frame === 1'b1) break;
    end
    checks++;
    if (n !== 255) begin errors++; $display("FAIL postreset_frame: got %0d edges want 255", n); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_decode();
    test_lz();
    test_dp();
    test_bright();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
